// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 8N1 UART receiver with framing-error strobe and saturating error count.
// Optional even-parity (8E1) frames when UART_RX_PARITY_EN is defined.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ERRCNT_W     = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rx,
  output logic                rxReady,
  output logic [7:0]          rxData,
  output logic                frame_err,
  output logic [ERRCNT_W-1:0] err_count,
  output logic                rx_busy
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_WAITIDLE,
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_rx_meta;
  logic            r_rx_s;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            w_cnt_clr;
  logic            w_cnt_inc;
  logic            w_shift_en;
  logic            w_ready;
  logic            w_ferr;
  logic            w_cnt_last;
  logic            w_cnt_half;
`ifdef UART_RX_PARITY_EN
  logic            r_parity;
  logic            r_par_err;
  logic            w_par_sample;
`endif

  assign w_cnt_last = (r_clk_cnt == LAST_CNT);
  assign w_cnt_half = (r_clk_cnt == HALF_CNT);
  assign rx_busy    = (r_state != S_IDLE) && (r_state != S_WAITIDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= S_WAITIDLE;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_state   <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_shift_en = 1'b0;
    w_ready    = 1'b0;
    w_ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_sample = 1'b0;
`endif
    case (r_state)
      S_WAITIDLE: begin
        if (!r_rx_s) begin
          w_cnt_clr = 1'b1;
        end else if (w_cnt_last) begin
          w_cnt_clr = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!r_rx_s) w_next = S_START;
      end
      S_START: begin
        // Any return to high before mid-start is a glitch; abort early so rx_busy drops fast.
        if (r_rx_s) begin
          w_cnt_clr = 1'b1;
          w_next    = S_IDLE;
        end else if (w_cnt_half) begin
          w_cnt_clr = 1'b1;
          w_next    = S_DATA;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DATA: begin
        if (w_cnt_last) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_next = S_PARITY;
`else
            w_next = S_STOP;
`endif
          end
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_cnt_last) begin
          w_cnt_clr    = 1'b1;
          w_par_sample = 1'b1;
          w_next       = S_STOP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_cnt_last) begin
          w_cnt_clr = 1'b1;
          if (!r_rx_s) begin
            w_ferr = 1'b1;
            w_next = S_WAITIDLE;
`ifdef UART_RX_PARITY_EN
          end else if (r_par_err) begin
            w_ferr = 1'b1;
            w_next = S_IDLE;
`endif
          end else begin
            w_ready = 1'b1;
            w_next  = S_IDLE;
          end
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_next = S_WAITIDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      rxReady   <= 1'b0;
      rxData    <= '0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      if (w_cnt_clr) begin
        r_clk_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end
      if (r_state == S_IDLE) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_shift_en) r_shift <= {r_rx_s, r_shift[7:1]};
      rxReady   <= w_ready;
      frame_err <= w_ferr;
      if (w_ready) rxData <= r_shift;
      if (w_ferr && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity  <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_parity  <= 1'b0;
        r_par_err <= 1'b0;
      end else if (w_shift_en) begin
        r_parity <= r_parity ^ r_rx_s;
      end else if (w_par_sample) begin
        // Even parity: data ones plus parity bit must be even.
        r_par_err <= r_parity ^ r_rx_s;
      end
    end
  end
`endif

endmodule
